// File: rtl/pwm_axil_slave.sv
// -----------------------------------------------------------------------------
// pwm_axil_slave
//
// AXI4-Lite slave front-end for the multi-channel PWM register file. Converts
// host AXI4-Lite write/read transactions into single-cycle decoded register
// strobes and returns OKAY/SLVERR responses. One write and one read may be
// outstanding at the same time; the two channel FSMs are fully independent.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   s_aw*, s_w*, s_b*          AXI4-Lite write address / data / response
//   s_ar*, s_r*                AXI4-Lite read address / data
//   write_en/addr/data         one-cycle register-file write strobe
//   read_en/addr               one-cycle register-file read strobe
//   read_data, read_valid      register-file read return (one cycle after read_en)
//
// Register index = addr[ADDR_WIDTH+1:2]; addr[1:0] is ignored. An address is in
// range when every bit above ADDR_WIDTH+1 is zero and the index is < DEPTH.
// -----------------------------------------------------------------------------
module pwm_axil_slave #(
    parameter  int AXI_ADDR_WIDTH = 32,
    parameter  int AXI_DATA_WIDTH = 32,
    parameter  int REG_WIDTH      = 16,
    parameter  int NUM_CHANNELS   = 4,
    localparam int DEPTH          = 2 + 2 * NUM_CHANNELS,
    localparam int ADDR_WIDTH     = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                        s_awvalid,
    output logic                        s_awready,

    input  logic [AXI_DATA_WIDTH-1:0]   s_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                        s_wvalid,
    output logic                        s_wready,

    output logic [1:0]                  s_bresp,
    output logic                        s_bvalid,
    input  logic                        s_bready,

    input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
    input  logic                        s_arvalid,
    output logic                        s_arready,

    output logic [AXI_DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]                  s_rresp,
    output logic                        s_rvalid,
    input  logic                        s_rready,

    output logic                        write_en,
    output logic [ADDR_WIDTH-1:0]       write_addr,
    output logic [REG_WIDTH-1:0]        write_data,

    output logic                        read_en,
    output logic [ADDR_WIDTH-1:0]       read_addr,
    input  logic [REG_WIDTH-1:0]        read_data,
    input  logic                        read_valid
);

    localparam int               STRB_LANES  = REG_WIDTH / 8;
    localparam logic [1:0]       RESP_OKAY   = 2'b00;
    localparam logic [1:0]       RESP_SLVERR = 2'b10;
    // One extra bit so the comparison still works when DEPTH is a power of two.
    localparam logic [ADDR_WIDTH:0] DEPTH_CMP = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP}         w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP}  r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] aw_index;
    logic [ADDR_WIDTH-1:0] ar_index;
    logic                  aw_in_range;
    logic                  ar_in_range;
    logic                  strb_full;

    assign aw_index    = s_awaddr[ADDR_WIDTH+1:2];
    assign ar_index    = s_araddr[ADDR_WIDTH+1:2];
    assign aw_in_range = (s_awaddr[AXI_ADDR_WIDTH-1:ADDR_WIDTH+2] == '0)
                       && ({1'b0, aw_index} < DEPTH_CMP);
    assign ar_in_range = (s_araddr[AXI_ADDR_WIDTH-1:ADDR_WIDTH+2] == '0)
                       && ({1'b0, ar_index} < DEPTH_CMP);
    // Only the lanes that carry register bits must be enabled.
    assign strb_full   = &s_wstrb[STRB_LANES-1:0];

    // Byte offset, upper data bits and upper strobe lanes carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_awaddr[1:0], s_araddr[1:0], s_wdata, s_wstrb};

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_index_q;
    logic                  aw_ok_q;
    logic [REG_WIDTH-1:0]  w_data_q;
    logic                  w_strb_ok_q;

    logic                  aw_fire;
    logic                  w_fire;
    logic                  aw_have;
    logic                  w_have;
    logic [ADDR_WIDTH-1:0] wr_index;
    logic [REG_WIDTH-1:0]  wr_data;
    logic                  wr_legal;

    assign aw_fire  = s_awvalid & s_awready;
    assign w_fire   = s_wvalid & s_wready;
    assign aw_have  = aw_held | aw_fire;
    assign w_have   = w_held | w_fire;
    // Use the live bus value on the handshake cycle, the held copy otherwise,
    // so that AW and W may complete in either order or together.
    assign wr_index = aw_fire ? aw_index : aw_index_q;
    assign wr_data  = w_fire ? s_wdata[REG_WIDTH-1:0] : w_data_q;
    assign wr_legal = (aw_fire ? aw_in_range : aw_ok_q)
                    & (w_fire ? strb_full : w_strb_ok_q);

    // NOTE: state registers use non-blocking assignments so every always_ff
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state     <= W_IDLE;
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_index_q  <= '0;
            aw_ok_q     <= 1'b0;
            w_data_q    <= '0;
            w_strb_ok_q <= 1'b0;
            s_awready   <= 1'b0;
            s_wready    <= 1'b0;
            s_bvalid    <= 1'b0;
            s_bresp     <= RESP_OKAY;
            write_en    <= 1'b0;
            write_addr  <= '0;
            write_data  <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_fire) begin
                        aw_index_q <= aw_index;
                        aw_ok_q    <= aw_in_range;
                    end
                    if (w_fire) begin
                        w_data_q    <= s_wdata[REG_WIDTH-1:0];
                        w_strb_ok_q <= strb_full;
                    end
                    if (aw_have && w_have) begin
                        w_state   <= W_EXEC;
                        aw_held   <= 1'b0;
                        w_held    <= 1'b0;
                        s_awready <= 1'b0;
                        s_wready  <= 1'b0;
                        write_en  <= wr_legal;
                        s_bresp   <= wr_legal ? RESP_OKAY : RESP_SLVERR;
                        if (wr_legal) begin
                            write_addr <= wr_index;
                            write_data <= wr_data;
                        end
                    end else begin
                        // Also raises both readies on the first clock after reset.
                        aw_held   <= aw_have;
                        w_held    <= w_have;
                        s_awready <= !aw_have;
                        s_wready  <= !w_have;
                    end
                end
                W_EXEC: begin
                    write_en <= 1'b0;
                    s_bvalid <= 1'b1;
                    w_state  <= W_RESP;
                end
                W_RESP: begin
                    if (s_bready) begin
                        s_bvalid  <= 1'b0;
                        s_awready <= 1'b1;
                        s_wready  <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    logic ar_fire;
    assign ar_fire = s_arvalid & s_arready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= R_IDLE;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rresp   <= RESP_OKAY;
            s_rdata   <= '0;
            read_en   <= 1'b0;
            read_addr <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_fire) begin
                        s_arready <= 1'b0;
                        if (ar_in_range) begin
                            read_en   <= 1'b1;
                            read_addr <= ar_index;
                            r_state   <= R_REQ;
                        end else begin
                            // Out of range: answer at once, no register access.
                            s_rvalid <= 1'b1;
                            s_rresp  <= RESP_SLVERR;
                            s_rdata  <= '0;
                            r_state  <= R_RESP;
                        end
                    end else begin
                        s_arready <= 1'b1;
                    end
                end
                R_REQ: begin
                    read_en <= 1'b0;
                    r_state <= R_WAIT;
                end
                R_WAIT: begin
                    if (read_valid) begin
                        s_rdata  <= AXI_DATA_WIDTH'(read_data);
                        s_rresp  <= RESP_OKAY;
                        s_rvalid <= 1'b1;
                        r_state  <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s_rready) begin
                        s_rvalid  <= 1'b0;
                        s_arready <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule
